// File: rtl/secure_router_pkg.sv
// secure_router_pkg: shared widths, packet field slices, FSM states and round-robin pick
package secure_router_pkg;
  localparam int NUM_PORTS = 4;
  localparam int DEST_W = 2;
  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int PKT_W = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;
  typedef enum logic {IDLE, ROUTE} state_t;
  function automatic logic [DEST_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [DEST_W-1:0] ptr);
    logic [DEST_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ptr + DEST_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/secure_router_sched_if.sv
// secure_router_sched_if: source request/grant and per-destination valid/ready slot bundle
interface secure_router_sched_if;
  import secure_router_pkg::*;
  logic [NUM_PORTS-1:0] req, gnt, vld, rdy;
  logic [PKT_W-1:0] pkt0, pkt1, pkt2, pkt3;
  logic [CODE_W-1:0] d_out0, d_out1, d_out2, d_out3;
  modport master (output req, pkt0, pkt1, pkt2, pkt3, rdy, input gnt, vld, d_out0, d_out1, d_out2, d_out3);
  modport slave (input req, pkt0, pkt1, pkt2, pkt3, rdy, output gnt, vld, d_out0, d_out1, d_out2, d_out3);
endinterface

// File: rtl/hamming_encoder.sv
// hamming_encoder: Hamming(7,4) codeword {d3,d2,d1,p4,d0,p2,p1}
module hamming_encoder (
  input  logic [3:0] d,
  output logic [6:0] c
);
  assign c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
endmodule

// File: rtl/secure_router_sched.sv
// secure_router_sched: round-robin Hamming(7,4) encode-and-route scheduler; SECURE_ROUTER_STATS_EN adds saturating per-destination counters
module secure_router_sched
  import secure_router_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  secure_router_sched_if.slave bus,
  output logic busy
`ifdef SECURE_ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] pkt_cnt2,
  output logic [CNT_W-1:0] pkt_cnt3
`endif
);
  state_t state, state_nx;
  logic [DEST_W-1:0] ptr, win, dst;
  logic [PKT_W-1:0] stage;
  logic [PKT_W-1:0] pkt [NUM_PORTS];
  logic [CODE_W-1:0] slot [NUM_PORTS];
  logic [CODE_W-1:0] code;
  logic [NUM_PORTS-1:0] gnt_q, vld_q, load;
  logic take, free;
  assign pkt[0] = bus.pkt0;
  assign pkt[1] = bus.pkt1;
  assign pkt[2] = bus.pkt2;
  assign pkt[3] = bus.pkt3;
  assign win = rr_pick(bus.req, ptr);
  assign dst = stage[DEST_HI:DEST_LO];
  assign free = !vld_q[dst] || bus.rdy[dst];
  assign take = state == IDLE && |bus.req;
  assign load = (state == ROUTE && free) ? NUM_PORTS'(1) << dst : '0;
  hamming_encoder u_enc (.d(stage[DATA_HI:DATA_LO]), .c(code));
  always_comb begin
    state_nx = state;
    if (take) state_nx = ROUTE;
    if (state == ROUTE && free) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Grant pulses only on the IDLE acceptance edge, so a stalled ROUTE never re-grants.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      stage <= '0;
      gnt_q <= '0;
    end else begin
      gnt_q <= take ? NUM_PORTS'(1) << win : '0;
      if (take) begin
        ptr <= win + DEST_W'(1);
        stage <= pkt[win];
      end
    end
  // A reload on the same edge as a drain keeps the slot valid.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (load[i]) begin
          slot[i] <= code;
          vld_q[i] <= 1'b1;
        end else if (vld_q[i] && bus.rdy[i]) begin
          slot[i] <= '0;
          vld_q[i] <= 1'b0;
        end
    end
  assign bus.gnt = gnt_q;
  assign bus.vld = vld_q;
  assign bus.d_out0 = slot[0];
  assign bus.d_out1 = slot[1];
  assign bus.d_out2 = slot[2];
  assign bus.d_out3 = slot[3];
  assign busy = state != IDLE;
`ifdef SECURE_ROUTER_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_PORTS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (load[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  assign pkt_cnt0 = cnt[0];
  assign pkt_cnt1 = cnt[1];
  assign pkt_cnt2 = cnt[2];
  assign pkt_cnt3 = cnt[3];
`endif
endmodule
